// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage PPCPU pipeline.
// Optional HAZ_PERF_CNT_EN adds StallCnt/FlushCnt performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic [4:0] ID_Rw,
  input  logic       ID_RegWr,
  input  logic       ID_MemtoReg,
  input  logic       M_PCSrc,
  output logic       PC_WE,
  output logic       IF_ID_WE,
  output logic       IF_ID_Flush,
  output logic       ID_Ex_Bubble,
  output logic       Ex_Mem_Flush,
  output logic [1:0] FwdA,
  output logic [1:0] FwdB,
  output logic       ID_BypA,
  output logic       ID_BypB
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {HOLD, RUN, STALL, FLUSH} state_e;

  localparam logic [2:0] HOLD_INIT   = 3'(RESET_HOLD);
  localparam logic [2:0] LAT_INIT    = 3'(LOAD_LAT - 1);
  localparam bit         MULTI_STALL = (LOAD_LAT > 1);

  state_e     st_q, st_d;
  logic [2:0] cnt_q, cnt_d;

  logic       ex_v, ex_regwr, ex_mtr, ex_use_rs, ex_use_rt;
  logic [4:0] ex_rw, ex_rs, ex_rt;
  logic       mem_v, mem_regwr, mem_mtr;
  logic [4:0] mem_rw;
  logic       wb_v, wb_regwr;
  logic [4:0] wb_rw;
  logic       load_use;

  function automatic logic slot_writes(input logic v, input logic wr,
                                       input logic [4:0] rw, input logic [4:0] r);
    return v & wr & (rw == r) & (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                         input logic m_v, input logic m_wr, input logic [4:0] m_rw,
                                         input logic m_mtr, input logic w_v, input logic w_wr,
                                         input logic [4:0] w_rw);
    if (use_src & slot_writes(m_v, m_wr, m_rw, src) & ~m_mtr) return 2'b01;
    if (use_src & slot_writes(w_v, w_wr, w_rw, src))           return 2'b10;
    return 2'b00;
  endfunction

  assign load_use = ex_v & ex_mtr & (ex_rw != 5'd0) &
                    ((ID_UseRs & (ID_Rs == ex_rw)) | (ID_UseRt & (ID_Rt == ex_rw)));

  // Shadow scoreboard: stall/flush decisions of this cycle decide what enters each slot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_v <= 1'b0; ex_regwr <= 1'b0; ex_mtr <= 1'b0; ex_use_rs <= 1'b0; ex_use_rt <= 1'b0;
      ex_rw <= '0; ex_rs <= '0; ex_rt <= '0;
      mem_v <= 1'b0; mem_regwr <= 1'b0; mem_mtr <= 1'b0; mem_rw <= '0;
      wb_v <= 1'b0; wb_regwr <= 1'b0; wb_rw <= '0;
    end else begin
      ex_v      <= ~ID_Ex_Bubble;
      ex_regwr  <= ID_RegWr;
      ex_mtr    <= ID_MemtoReg;
      ex_use_rs <= ID_UseRs;
      ex_use_rt <= ID_UseRt;
      ex_rw     <= ID_Rw;
      ex_rs     <= ID_Rs;
      ex_rt     <= ID_Rt;
      mem_v     <= ex_v & ~Ex_Mem_Flush;
      mem_regwr <= ex_regwr;
      mem_mtr   <= ex_mtr;
      mem_rw    <= ex_rw;
      wb_v      <= mem_v;
      wb_regwr  <= mem_regwr;
      wb_rw     <= mem_rw;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_q  <= HOLD;
      cnt_q <= HOLD_INIT;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Counters leave HOLD/STALL on the edge where they would decrement to zero.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      HOLD: begin
        if (cnt_q <= 3'd1) begin
          st_d  = RUN;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      STALL: begin
        if (M_PCSrc) begin
          st_d  = FLUSH;
          cnt_d = '0;
        end else if (cnt_q <= 3'd1) begin
          st_d  = RUN;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RUN, FLUSH: begin
        if (M_PCSrc) begin
          st_d  = FLUSH;
          cnt_d = '0;
        end else if (load_use) begin
          st_d  = MULTI_STALL ? STALL : RUN;
          cnt_d = LAT_INIT;
        end else begin
          st_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    PC_WE        = 1'b0;
    IF_ID_WE     = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_Ex_Bubble = 1'b1;
    Ex_Mem_Flush = 1'b0;
    if (st_q != HOLD) begin
      if (M_PCSrc) begin
        PC_WE        = 1'b1;
        IF_ID_WE     = 1'b1;
        IF_ID_Flush  = 1'b1;
        ID_Ex_Bubble = 1'b1;
        Ex_Mem_Flush = 1'b1;
      end else if ((st_q == STALL) || load_use) begin
        PC_WE        = 1'b0;
        IF_ID_WE     = 1'b0;
        ID_Ex_Bubble = 1'b1;
      end else begin
        PC_WE        = 1'b1;
        IF_ID_WE     = 1'b1;
        ID_Ex_Bubble = 1'b0;
      end
    end
    FwdA    = fwd_sel(ex_use_rs, ex_rs, mem_v, mem_regwr, mem_rw, mem_mtr, wb_v, wb_regwr, wb_rw);
    FwdB    = fwd_sel(ex_use_rt, ex_rt, mem_v, mem_regwr, mem_rw, mem_mtr, wb_v, wb_regwr, wb_rw);
    ID_BypA = ID_UseRs & slot_writes(wb_v, wb_regwr, wb_rw, ID_Rs);
    ID_BypB = ID_UseRt & slot_writes(wb_v, wb_regwr, wb_rw, ID_Rt);
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if ((st_q != HOLD) && !PC_WE) StallCnt <= StallCnt + 32'd1;
      if (Ex_Mem_Flush)             FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (LOAD_LAT 1/3) against a cycle-level model.
module tb_pipe_hazard_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, ID_Rw;
  logic       ID_UseRs, ID_UseRt, ID_RegWr, ID_MemtoReg, M_PCSrc;

  logic [1:0]      pc_we, if_id_we, if_id_flush, bubble, exm_flush, byp_a, byp_b;
  logic [1:0][1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [1:0][31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.LOAD_LAT(1), .RESET_HOLD(2)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs),
    .ID_UseRt(ID_UseRt), .ID_Rw(ID_Rw), .ID_RegWr(ID_RegWr), .ID_MemtoReg(ID_MemtoReg),
    .M_PCSrc(M_PCSrc), .PC_WE(pc_we[0]), .IF_ID_WE(if_id_we[0]), .IF_ID_Flush(if_id_flush[0]),
    .ID_Ex_Bubble(bubble[0]), .Ex_Mem_Flush(exm_flush[0]), .FwdA(fwd_a[0]), .FwdB(fwd_b[0]),
    .ID_BypA(byp_a[0]), .ID_BypB(byp_b[0])
`ifdef HAZ_PERF_CNT_EN
    , .StallCnt(stall_cnt[0]), .FlushCnt(flush_cnt[0])
`endif
  );

  pipe_hazard_ctrl #(.LOAD_LAT(3), .RESET_HOLD(0)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs),
    .ID_UseRt(ID_UseRt), .ID_Rw(ID_Rw), .ID_RegWr(ID_RegWr), .ID_MemtoReg(ID_MemtoReg),
    .M_PCSrc(M_PCSrc), .PC_WE(pc_we[1]), .IF_ID_WE(if_id_we[1]), .IF_ID_Flush(if_id_flush[1]),
    .ID_Ex_Bubble(bubble[1]), .Ex_Mem_Flush(exm_flush[1]), .FwdA(fwd_a[1]), .FwdB(fwd_b[1]),
    .ID_BypA(byp_a[1]), .ID_BypB(byp_b[1])
`ifdef HAZ_PERF_CNT_EN
    , .StallCnt(stall_cnt[1]), .FlushCnt(flush_cnt[1])
`endif
  );

  typedef struct packed {
    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       bubble;
    logic       exm_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       byp_a;
    logic       byp_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] scnt;
    logic [31:0] fcnt;
`endif
  } out_t;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt, rw;
    bit       urs, urt, wr, mtr;
  } ins_t;

  // Model: pipe_m[k][0..2] are the instructions sitting in Ex, Mem, Wr.
  ins_t        pipe_m[2][3];
  int          hold_left[2];
  int          stall_left[2];
  int unsigned m_scnt[2], m_fcnt[2];
  int          lat_p[2]  = '{1, 3};
  int          hold_p[2] = '{2, 0};
  out_t        exp_cur[2];
  out_t        q0[$], q1[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  function automatic bit wr_hit(ins_t s, bit [4:0] r);
    return s.v && s.wr && (s.rw == r) && (r != 0);
  endfunction

  function automatic ins_t id_ins();
    ins_t i;
    i.v = 1; i.rs = ID_Rs; i.rt = ID_Rt; i.rw = ID_Rw;
    i.urs = ID_UseRs; i.urt = ID_UseRt; i.wr = ID_RegWr; i.mtr = ID_MemtoReg;
    return i;
  endfunction

  function automatic bit load_use_m(int k);
    ins_t e = pipe_m[k][0];
    return e.v && e.mtr && (e.rw != 0) &&
           ((ID_UseRs && (ID_Rs == e.rw)) || (ID_UseRt && (ID_Rt == e.rw)));
  endfunction

  function automatic logic [1:0] fwd_m(int k, bit use_src, bit [4:0] src);
    if (use_src && wr_hit(pipe_m[k][1], src) && !pipe_m[k][1].mtr) return 2'b01;
    if (use_src && wr_hit(pipe_m[k][2], src)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic out_t predict(int k);
    out_t o = '0;
    if (Reset || hold_left[k] > 0) begin
      o.bubble = 1;
    end else if (M_PCSrc) begin
      o.pc_we = 1; o.if_id_we = 1; o.if_id_flush = 1; o.bubble = 1; o.exm_flush = 1;
    end else if (stall_left[k] > 0 || load_use_m(k)) begin
      o.bubble = 1;
    end else begin
      o.pc_we = 1; o.if_id_we = 1;
    end
    o.fwd_a = fwd_m(k, pipe_m[k][0].urs, pipe_m[k][0].rs);
    o.fwd_b = fwd_m(k, pipe_m[k][0].urt, pipe_m[k][0].rt);
    o.byp_a = ID_UseRs && wr_hit(pipe_m[k][2], ID_Rs);
    o.byp_b = ID_UseRt && wr_hit(pipe_m[k][2], ID_Rt);
`ifdef HAZ_PERF_CNT_EN
    o.scnt = m_scnt[k];
    o.fcnt = m_fcnt[k];
`endif
    return o;
  endfunction

  task automatic advance(int k, out_t o);
    bit lu = load_use_m(k);
    bit in_hold = (hold_left[k] > 0);
    if (in_hold)                hold_left[k]--;
    else if (M_PCSrc)           stall_left[k] = 0;
    else if (stall_left[k] > 0) stall_left[k]--;
    else if (lu)                stall_left[k] = lat_p[k] - 1;
    if (!in_hold && !o.pc_we) m_scnt[k]++;
    if (o.exm_flush)          m_fcnt[k]++;
    pipe_m[k][2] = pipe_m[k][1];
    pipe_m[k][1] = pipe_m[k][0];
    if (o.exm_flush) pipe_m[k][1].v = 0;
    pipe_m[k][0] = id_ins();
    if (o.bubble) pipe_m[k][0].v = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe_m[k][s].v = 0;
      hold_left[k]  = (hold_p[k] == 0) ? 1 : hold_p[k];
      stall_left[k] = 0;
      m_scnt[k] = 0;
      m_fcnt[k] = 0;
    end
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) exp_cur[k] = predict(k);
    q0.push_back(exp_cur[0]);
    q1.push_back(exp_cur[1]);
    @(posedge Clk);
    if (!Reset) for (int k = 0; k < 2; k++) advance(k, exp_cur[k]);
    #1;
  endtask

  task automatic drive(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit [4:0] rw, input bit wr, input bit mtr, input bit pc);
    ID_Rs = rs; ID_Rt = rt; ID_UseRs = urs; ID_UseRt = urt;
    ID_Rw = rw; ID_RegWr = wr; ID_MemtoReg = mtr; M_PCSrc = pc;
    step();
  endtask

  task automatic nops(int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse(int n);
    #1;
    Reset = 1'b1;
    model_reset();
    repeat (n) step();
    Reset = 1'b0;
  endtask

  function automatic out_t get_act(int k);
    out_t a = '0;
    a.pc_we = pc_we[k]; a.if_id_we = if_id_we[k]; a.if_id_flush = if_id_flush[k];
    a.bubble = bubble[k]; a.exm_flush = exm_flush[k];
    a.fwd_a = fwd_a[k]; a.fwd_b = fwd_b[k]; a.byp_a = byp_a[k]; a.byp_b = byp_b[k];
`ifdef HAZ_PERF_CNT_EN
    a.scnt = stall_cnt[k]; a.fcnt = flush_cnt[k];
`endif
    return a;
  endfunction

  // Monitor: every cycle the DUTs present a full output vector; compare against the queue head.
  initial begin
    out_t e, a;
    forever begin
      @(negedge Clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          a = get_act(k);
          total++;
          if (a !== e) begin
            bad++;
            $display("FAIL outputs dut%0d cycle %0d: got %h expected %h", k, cyc, a, e);
          end
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    ID_Rs = '0; ID_Rt = '0; ID_Rw = '0;
    ID_UseRs = 0; ID_UseRt = 0; ID_RegWr = 0; ID_MemtoReg = 0; M_PCSrc = 0;
    model_reset();
    @(posedge Clk);
    #1;
    repeat (2) step();
    Reset = 1'b0;
    // hold window, with a branch that must be ignored
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    nops(3);
    // back-to-back add $3 / sub $3
    drive(1, 2, 1, 1, 3, 1, 0, 0);
    drive(3, 4, 1, 1, 5, 1, 0, 0);
    nops(3);
    // one unrelated instruction between producer and consumer
    drive(1, 2, 1, 1, 3, 1, 0, 0);
    drive(6, 7, 1, 1, 8, 1, 0, 0);
    drive(3, 4, 1, 1, 9, 1, 0, 0);
    nops(3);
    // lw $5 then Rt user held in ID while stalled
    drive(1, 2, 1, 0, 5, 1, 1, 0);
    repeat (4) drive(6, 5, 1, 1, 7, 1, 0, 0);
    nops(4);
    // branch resolved while ID holds a load-use consumer
    drive(1, 2, 1, 0, 5, 1, 1, 0);
    drive(6, 5, 1, 1, 7, 1, 0, 1);
    drive(6, 5, 1, 1, 7, 1, 0, 0);
    nops(4);
    // producer and consumer of $0
    drive(1, 2, 1, 1, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 4, 1, 0, 0);
    drive(0, 0, 1, 1, 4, 1, 0, 0);
    drive(0, 0, 1, 1, 4, 1, 0, 0);
    nops(2);
    // async reset while the LOAD_LAT=3 instance is stalling
    drive(1, 2, 1, 0, 5, 1, 1, 0);
    drive(6, 5, 0, 1, 7, 1, 0, 0);
    drive(6, 5, 0, 1, 7, 1, 0, 0);
    reset_pulse(2);
    nops(4);
    for (int i = 0; i < 600; i++) begin
      bit wr = 1'($urandom_range(0, 1));
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), wr, wr & 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0));
      if (i == 300) reset_pulse(1);
    end
    nops(1);
    repeat (3) @(negedge Clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard, forwarding and flush controller for the 5-stage PPCPU pipeline (IF, ID, Ex, Mem, Wr).
- Keeps a shadow scoreboard of in-flight destination registers for the Ex, Mem and Wr slots.
- Drives PC/IF_ID write enables, pipeline bubbles/flushes, Ex-stage operand forwarding selects and ID-stage write-back bypass.
- Sits beside the datapath: inputs come from ID decode and the Mem-stage branch decision; outputs feed the PC, IF_ID, ID_Ex and Ex_Mem registers and the operand muxes.

Parameters:
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..3)
RESET_HOLD, 2, cycles after reset release during which fetch is frozen (0..7)

Ports:
Clk  in  1  pipeline clock, rising edge
Reset  in  1  asynchronous, active-high reset
ID_Rs  in  5  Rs field of the instruction in ID
ID_Rt  in  5  Rt field of the instruction in ID
ID_UseRs  in  1  ID instruction reads Rs
ID_UseRt  in  1  ID instruction reads Rt
ID_Rw  in  5  destination register after RegDst selection
ID_RegWr  in  1  ID instruction writes the register file
ID_MemtoReg  in  1  ID instruction is a load
M_PCSrc  in  1  taken branch/jump resolved in Mem
PC_WE  out  1  PC write enable
IF_ID_WE  out  1  IF_ID write enable
IF_ID_Flush  out  1  IF_ID loads a NOP
ID_Ex_Bubble  out  1  ID_Ex loads a NOP
Ex_Mem_Flush  out  1  Ex_Mem loads a NOP
FwdA  out  2  Ex operand A select: 00 busA, 01 M_ALUout, 10 W_RegDin
FwdB  out  2  Ex operand B select, same encoding as FwdA
ID_BypA  out  1  ID busA takes W_RegDin
ID_BypB  out  1  ID busB takes W_RegDin

Behaviour:
- Scoreboard:
  - Slots EX, MEM and WB each hold {valid, Rw, RegWr, MemtoReg}; the EX slot also holds Rs/Rt and their use bits.
  - Each rising edge shifts ID→EX→MEM→WB. Bubble or flush loads valid=0.
  - While stalled, the EX slot receives a bubble and the MEM/WB slots still shift.
- A slot "writes r" iff valid & RegWr & Rw==r & r!=0. Register 0 never matches.
- Forwarding (combinational, from EX-slot sources):
  - FwdA=01 if MEM writes Rs & !MEM.MemtoReg.
  - Otherwise FwdA=10 if WB writes Rs.
  - Otherwise 00. FwdB is the same rule on Rt.
  - A load in MEM is never forwarded from MEM.
- ID bypass: ID_BypA=ID_UseRs & WB writes ID_Rs; ID_BypB likewise on Rt.
- Load-use hazard: EX slot is a valid load with Rw!=0 matching a used ID source.
- FSM states: HOLD, RUN, STALL, FLUSH.
  - HOLD: entered on reset. A counter loaded with RESET_HOLD; PC_WE=IF_ID_WE=0, ID_Ex_Bubble=1. Goes to RUN when the counter reaches 0 (RESET_HOLD=0 means RUN on the first edge).
  - RUN: all enables 1, no bubble. On load-use: assert PC_WE=IF_ID_WE=0 and ID_Ex_Bubble=1 in the same cycle, load the counter with LOAD_LAT-1, go to STALL if LOAD_LAT>1, else stay in RUN.
  - STALL: same outputs as the load-use cycle. Decrement the counter; return to RUN at 0.
  - FLUSH: entered from any non-HOLD state when M_PCSrc=1. In that cycle IF_ID_Flush=ID_Ex_Bubble=Ex_Mem_Flush=1 and PC_WE=1 so the PC takes the target. EX and MEM slots are invalidated. Next cycle goes to RUN.
  - FLUSH is a one-cycle marker; a fresh hazard in the following cycle is evaluated normally.
- Priority: M_PCSrc flush > load-use stall > run. A flush during STALL aborts the stall and clears the counter.
- Reset (asynchronous, mid-operation allowed):
  - All slots invalid, state HOLD, counter=RESET_HOLD.
  - Outputs: PC_WE=0, IF_ID_WE=0, IF_ID_Flush=0, ID_Ex_Bubble=1, Ex_Mem_Flush=0, FwdA=FwdB=00, ID_BypA=ID_BypB=0.
- M_PCSrc is ignored in HOLD.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: adds 32-bit outputs StallCnt (cycles with PC_WE=0 outside HOLD) and FlushCnt (cycles with a flush).
  - Both reset to 0 and wrap from 32'hFFFFFFFF to 0.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, RESET_HOLD=2 → PC_WE=0 for exactly 2 edges after Reset falls, then 1; ID_Ex_Bubble=1 during hold.
- Back-to-back: add $3 then sub using $3 → FwdA=01 in the sub's Ex cycle. With one unrelated instruction between them → FwdA=10. No stall in either case.
- lw $5 followed by a user of $5 in Rt, LOAD_LAT=1 → exactly one cycle of PC_WE=IF_ID_WE=0 with ID_Ex_Bubble=1, then FwdB=10. With LOAD_LAT=3 → 3 stall cycles.
- M_PCSrc=1 while the ID instruction is a load-use consumer → flush wins: PC_WE=1, all three flush/bubble outputs 1, no stall afterwards, StallCnt unchanged, FlushCnt+1.
- Producer writes $0, consumer reads $0 → FwdA=FwdB=00, no stall, ID_BypA=0.
- Reset asserted mid-STALL → outputs take their reset values asynchronously; after release the controller re-enters HOLD with the full RESET_HOLD count.
